// File: rtl/fp_adder_rr_scheduler_pkg.sv
// Shared constants, types and helpers for the round-robin FP adder scheduler.
package fp_adder_rr_scheduler_pkg;

  localparam int FLAG_UF   = 0;
  localparam int FLAG_OF   = 1;
  localparam int FLAG_INV  = 2;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sched_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((32'sd1 <<< r) < value) r = r + 1;
      else r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_adder_rr_scheduler_fp_adder.sv
// Combinational IEEE-754 style adder, round-to-nearest-even, with subnormal support.
module floating_point_adder
  import fp_adder_rr_scheduler_pkg::*;
#(
  parameter int EXPONENT_WIDTH = DEF_EXP_W,
  parameter int MANTISSA_WIDTH = DEF_MAN_W
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] i_a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] i_b,
  input  logic                                   i_subtract,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] o_result,
  output logic [2:0]                             o_flags
);

  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int SW = MW + 4;
  localparam int XW = EW + 2;
  localparam logic [XW-1:0] EXP_MAX = {2'b00, {EW{1'b1}}};
  localparam logic [EW+MW:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic          w_sa, w_sb, w_sl, w_ss, w_swap, w_sticky, w_rup, w_ovf;
  logic [EW-1:0] w_ea, w_eb;
  logic [MW-1:0] w_ma, w_mb, w_mant;
  logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [XW-1:0] w_el, w_es, w_diff, w_lz, w_shift, w_exp_n, w_exp_f;
  logic [SW-1:0] w_xl, w_xs, w_xs_sh, w_norm;
  logic [SW:0]   w_sum;
  logic [MW+1:0] w_rnd;

  assign w_sa = i_a[EW+MW];
  assign w_sb = i_b[EW+MW] ^ i_subtract;
  assign w_ea = i_a[EW+MW-1:MW];
  assign w_eb = i_b[EW+MW-1:MW];
  assign w_ma = i_a[MW-1:0];
  assign w_mb = i_b[MW-1:0];
  assign w_a_nan = (&w_ea) & (|w_ma);
  assign w_b_nan = (&w_eb) & (|w_mb);
  assign w_a_inf = (&w_ea) & ~(|w_ma);
  assign w_b_inf = (&w_eb) & ~(|w_mb);

  // Align, add, normalise and round the finite operands.
  always_comb begin
    w_swap = {w_eb, w_mb} > {w_ea, w_ma};
    w_sl   = w_swap ? w_sb : w_sa;
    w_ss   = w_swap ? w_sa : w_sb;
    w_el   = w_swap ? XW'(w_eb | EW'(w_eb == '0)) : XW'(w_ea | EW'(w_ea == '0));
    w_es   = w_swap ? XW'(w_ea | EW'(w_ea == '0)) : XW'(w_eb | EW'(w_eb == '0));
    w_xl   = w_swap ? {|w_eb, w_mb, 3'b000} : {|w_ea, w_ma, 3'b000};
    w_xs   = w_swap ? {|w_ea, w_ma, 3'b000} : {|w_eb, w_mb, 3'b000};
    w_diff = w_el - w_es;

    w_sticky = 1'b0;
    for (int k = 0; k < SW; k++) begin
      w_sticky = w_sticky | (w_xs[k] & (XW'(k) < w_diff));
    end
    if (w_diff >= XW'(SW)) w_xs_sh = '0;
    else w_xs_sh = w_xs >> w_diff;
    w_xs_sh[0] = w_xs_sh[0] | w_sticky;

    if (w_sl ^ w_ss) w_sum = {1'b0, w_xl} - {1'b0, w_xs_sh};
    else w_sum = {1'b0, w_xl} + {1'b0, w_xs_sh};

    w_lz = XW'(SW);
    for (int k = 0; k < SW; k++) begin
      w_lz = w_sum[k] ? XW'(SW - 1 - k) : w_lz;
    end

    // A carry-out shifts right by one; otherwise shift left but never below exponent 1.
    w_shift = '0;
    if (w_sum[SW]) begin
      w_norm  = w_sum[SW:1] | {{(SW-1){1'b0}}, w_sum[0]};
      w_exp_n = w_el + XW'(1);
    end else begin
      w_shift = (w_lz < w_el) ? w_lz : (w_el - XW'(1));
      w_norm  = w_sum[SW-1:0] << w_shift;
      w_exp_n = w_el - w_shift;
    end

    w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd = {1'b0, w_norm[SW-1:3]} + (MW+2)'(w_rup);
    if (w_rnd[MW+1]) begin
      w_exp_f = w_exp_n + XW'(1);
      w_mant  = '0;
    end else begin
      w_exp_f = w_rnd[MW] ? w_exp_n : '0;
      w_mant  = w_rnd[MW-1:0];
    end
    w_ovf = (w_exp_f >= EXP_MAX);
  end

  // Special-value resolution and final packing.
  always_comb begin
    o_flags  = 3'b000;
    o_result = '0;
    if (w_a_nan || w_b_nan) begin
      o_result = QNAN;
      o_flags[FLAG_INV] = (w_a_nan & ~w_ma[MW-1]) | (w_b_nan & ~w_mb[MW-1]);
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      o_result = QNAN;
      o_flags[FLAG_INV] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      o_result = {w_a_inf ? w_sa : w_sb, {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_sum == '0) begin
      o_result = {w_sl & w_ss, {(EW+MW){1'b0}}};
    end else if (w_ovf) begin
      o_result = {w_sl, {EW{1'b1}}, {MW{1'b0}}};
      o_flags[FLAG_OF] = 1'b1;
    end else begin
      o_result = {w_sl, w_exp_f[EW-1:0], w_mant};
      o_flags[FLAG_UF] = (w_exp_f == '0) & (|w_norm[2:0]);
    end
  end

endmodule

// File: rtl/fp_adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after the pointer wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_pointer,
  output logic [N-1:0]  o_grant
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_grot;
  logic         w_seen;

  // Rotate so the pointer position lands on bit 0, then pick the lowest set bit.
  assign w_rot = N'({i_req, i_req} >> i_pointer);

  // Lowest-set-bit priority pick on the rotated request vector.
  always_comb begin
    w_seen = 1'b0;
    w_grot = '0;
    for (int k = 0; k < N; k++) begin
      w_grot[k] = w_rot[k] & ~w_seen;
      w_seen    = w_seen | w_rot[k];
    end
  end

  assign o_grant = N'(({w_grot, w_grot} << i_pointer) >> N);

endmodule

// File: rtl/fp_adder_rr_scheduler.sv
// Round-robin scheduler sharing one FP adder between NUM_REQ requesters,
// with a single registered, backpressured result slot.
module fp_adder_rr_scheduler
  import fp_adder_rr_scheduler_pkg::*;
#(
  parameter int EXPONENT_WIDTH  = DEF_EXP_W,
  parameter int MANTISSA_WIDTH  = DEF_MAN_W,
  parameter int NUM_REQ         = 4,
  parameter int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  parameter int ID_WIDTH        = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*FLOAT_BIT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*FLOAT_BIT_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]                 req_subtract,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [FLOAT_BIT_WIDTH-1:0]         out_result,
  output logic [2:0]                         out_flags,
  output logic [ID_WIDTH-1:0]                out_id
);

  localparam int FW = FLOAT_BIT_WIDTH;

  sched_state_t         r_state;
  logic [ID_WIDTH-1:0]  r_ptr;
  logic [ID_WIDTH-1:0]  r_id;
  logic [FW-1:0]        r_result;
  logic [2:0]           r_flags;
  logic                 r_valid;

  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_accept;
  logic                 w_fire;
  logic [ID_WIDTH-1:0]  w_win_id;
  logic [ID_WIDTH-1:0]  w_ptr_next;
  logic [FW-1:0]        w_a, w_b, w_sum;
  logic                 w_sub;
  logic [2:0]           w_flags;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_WIDTH)
  ) u_arb (
    .i_req     (req_valid),
    .i_pointer (r_ptr),
    .o_grant   (w_grant)
  );

  // A stalled full slot blocks all grants; reset forces ready low.
  assign w_accept  = (r_state == ST_EMPTY) || out_ready;
  assign req_ready = rst ? '0 : (w_grant & {NUM_REQ{w_accept}});
  assign w_fire    = |req_ready;

  // Encode the one-hot grant and mux the winner's operands.
  always_comb begin
    w_win_id = '0;
    w_a      = '0;
    w_b      = '0;
    w_sub    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_win_id = w_win_id | (w_grant[k] ? ID_WIDTH'(k) : '0);
      w_a      = w_a | (req_a[k*FW +: FW] & {FW{w_grant[k]}});
      w_b      = w_b | (req_b[k*FW +: FW] & {FW{w_grant[k]}});
      w_sub    = w_sub | (req_subtract[k] & w_grant[k]);
    end
  end

  assign w_ptr_next = (w_win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : (w_win_id + ID_WIDTH'(1));

  floating_point_adder #(
    .EXPONENT_WIDTH (EXPONENT_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_add (
    .i_a        (w_a),
    .i_b        (w_b),
    .i_subtract (w_sub),
    .o_result   (w_sum),
    .o_flags    (w_flags)
  );

  // Output slot FSM: load on handshake, drain on out_ready, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_valid  <= 1'b0;
      r_ptr    <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_flags  <= 3'b000;
    end else begin
      case (r_state)
        ST_EMPTY, ST_FULL: begin
          if (w_fire) begin
            r_state  <= ST_FULL;
            r_valid  <= 1'b1;
            r_ptr    <= w_ptr_next;
            r_id     <= w_win_id;
            r_result <= w_sum;
            r_flags  <= w_flags;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end else begin
            r_state <= r_state;
            r_valid <= r_valid;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;
  assign out_id     = r_id;

endmodule

// File: tb/tb_fp_adder_rr_scheduler.sv
// Directed, table-driven bench for fp_adder_rr_scheduler (NUM_REQ=4, binary32).
module tb_fp_adder_rr_scheduler;

  localparam int NR = 4;
  localparam int FW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*FW-1:0] req_a = '0;
  logic [NR*FW-1:0] req_b = '0;
  logic [NR-1:0]    req_subtract = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [FW-1:0]    out_result;
  logic [2:0]       out_flags;
  logic [1:0]       out_id;

  int n_checks = 0;
  int n_errors = 0;

  fp_adder_rr_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_subtract (req_subtract),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_id       (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_r;
    logic [2:0]  exp_f;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] rr_exp[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[id*FW +: FW] = a;
    req_b[id*FW +: FW] = b;
    req_subtract[id]   = sub;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, 3'b000};
    vecs[1] = '{3, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    vecs[2] = '{3, 32'h469C4600, 32'h3DCCCCCD, 1'b0, 32'h469C4633, 3'b000};
    vecs[3] = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    vecs[4] = '{2, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vecs[5] = '{1, 32'h40A00000, 32'h40000000, 1'b1, 32'h40400000, 3'b000};
    vecs[6] = '{2, 32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 3'b000};
    vecs[7] = '{0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000};
    rr_exp[0] = 32'h40E00000;
    rr_exp[1] = 32'h41100000;
    rr_exp[2] = 32'h40000000;
    rr_exp[3] = 32'h40400000;

    // Reset state, with every requester asking.
    req_valid = 4'hF;
    @(negedge clk);
    #1;
    chk("rst_ready", {28'd0, req_ready}, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {29'd0, out_flags}, 32'h0);
    chk("rst_id", {30'd0, out_id}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // Single operations through the table.
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub);
      req_valid = 4'b0001 << vecs[i].id;
      out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", i), {28'd0, req_ready}, {28'd0, 4'b0001 << vecs[i].id});
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_r);
      chk($sformatf("vec%0d_flags", i), {29'd0, out_flags}, {29'd0, vecs[i].exp_f});
      chk($sformatf("vec%0d_id", i), {30'd0, out_id}, vecs[i].id);
    end

    // Round-robin with all requesters valid, from pointer 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 32'h40400000, 32'h40800000, 1'b0);
    set_req(1, 32'h410B3333, 32'h3E99999A, 1'b0);
    set_req(2, 32'h3F800000, 32'h3F800000, 1'b0);
    set_req(3, 32'h40A00000, 32'h40000000, 1'b1);
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("rr_ready0", {28'd0, req_ready}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d_valid", k), {31'd0, out_valid}, 32'h1);
      chk($sformatf("rr%0d_id", k), {30'd0, out_id}, k % 4);
      chk($sformatf("rr%0d_result", k), out_result, rr_exp[k % 4]);
      if (k < 4) chk($sformatf("rr%0d_next_ready", k), {28'd0, req_ready}, {28'd0, 4'b0001 << ((k + 1) % 4)});
    end

    // Backpressure: id0 result held while req2 waits.
    req_valid = 4'b0100;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), {28'd0, req_ready}, 32'h0);
      step();
      chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'h1);
      chk($sformatf("bp%0d_id", c), {30'd0, out_id}, 32'h0);
      chk($sformatf("bp%0d_result", c), out_result, 32'h40E00000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = '0;
    chk("bp_new_id", {30'd0, out_id}, 32'h2);
    chk("bp_new_result", out_result, 32'h40000000);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'h0);
    chk("drain_id_kept", {30'd0, out_id}, 32'h2);
    chk("drain_result_kept", out_result, 32'h40000000);

    // Pointer fairness: after granting 1, req2 beats req0.
    req_valid = 4'b0010;
    #1;
    chk("fair_ready1", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b0101;
    #1;
    chk("fair_ready2", {28'd0, req_ready}, 32'h4);
    step();
    chk("fair_id2", {30'd0, out_id}, 32'h2);
    req_valid = 4'b0001;
    #1;
    chk("fair_ready0", {28'd0, req_ready}, 32'h1);
    step();
    chk("fair_id0", {30'd0, out_id}, 32'h0);
    req_valid = '0;
    out_ready = 1'b0;

    // Asynchronous reset while a result is pending.
    step();
    chk("ar_pending", {31'd0, out_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'h0);
    chk("ar_result", out_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0101;
    out_ready = 1'b1;
    #1;
    chk("ar_first_ready", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = '0;
    chk("ar_first_id", {30'd0, out_id}, 32'h0);
    chk("ar_first_result", out_result, 32'h40E00000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_adder_rr_scheduler.md
Name: fp_adder_rr_scheduler

Overview:
- Shares one combinational floating_point_adder instance between NUM_REQ independent requesters.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants one operation per cycle.
- The sum, the exception flags and the winning requester ID are captured in a single registered output slot with backpressure.
- Sits between the MAC/accumulate control units and the shared FP adder datapath.

Parameters:
- EXPONENT_WIDTH, 8, exponent field width passed to floating_point_adder.
- MANTISSA_WIDTH, 23, mantissa field width passed to floating_point_adder.
- NUM_REQ, 4, number of requesters (2..16).
- FLOAT_BIT_WIDTH, EXPONENT_WIDTH+MANTISSA_WIDTH+1, derived; not overridden.
- ID_WIDTH, max(1, clog2(NUM_REQ)), derived.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*FLOAT_BIT_WIDTH  packed operand A; requester i occupies slice i.
- req_b  in  NUM_REQ*FLOAT_BIT_WIDTH  packed operand B.
- req_subtract  in  NUM_REQ  per-requester subtract select.
- out_valid  out  1  result slot occupied.
- out_ready  in  1  consumer accepts the result.
- out_result  out  FLOAT_BIT_WIDTH  a+b or a-b.
- out_flags  out  3  {invalid_operation, overflow, underflow}.
- out_id  out  ID_WIDTH  index of the requester that produced the result.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_result=0, out_flags=0, out_id=0, RR pointer=0, state=EMPTY. req_ready is combinational and is 0 while rst=1.
- State machine:
  - EMPTY: the output slot is free.
  - FULL: the output slot holds an unconsumed result.
  - accept = (state==EMPTY) || out_ready.
- Arbitration is combinational:
  - Search req_valid starting at the RR pointer, wrapping modulo NUM_REQ; the first set bit wins.
  - grant one-hot; req_ready = grant & {NUM_REQ{accept}}.
- Mux the winner's a, b and subtract into the adder; the adder result is combinational.
- Transfer: a req_valid[i] & req_ready[i] handshake on edge k puts that result on the outputs after edge k (latency 1). out_id=i and state=FULL.
- RR pointer after a transfer is (i+1) mod NUM_REQ. The pointer is unchanged when no transfer occurs.
- FULL & out_ready & no valid request → EMPTY with out_valid=0. out_result, out_flags and out_id keep their last values.
- FULL & !out_ready → hold all outputs and req_ready=0 (full stall).
- Simultaneous drain and new grant in the same cycle → stay FULL with the new payload. This gives back-to-back throughput of 1 op/cycle.
- Fairness: with all requesters permanently valid and out_ready=1, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Requester rule: a, b and subtract must stay stable while valid is high and ready is low. The block never drops an asserted request, and valid may not be withdrawn before the handshake.
- A request that arrives in the same cycle as a stall is not granted, and the pointer does not move.
- Flags are the adder's flags for that exact operation; they are not sticky.
- Reset mid-operation: an asserted rst immediately clears out_valid, which discards any pending result. Requesters must re-issue after reset.

Decomposition:
- Shared defines header:
  - flag bit indices FLAG_UF=0, FLAG_OF=1, FLAG_INV=2;
  - the clog2 function macro;
  - default float widths (8/23).
- Sub-module rr_arbiter, parameter N:
  - inputs: req, pointer; output: one-hot grant.
  - purely combinational and reusable by other shared-datapath schedulers.
- The top level contains the operand mux, the floating_point_adder instance, the EMPTY/FULL state and the output register.

Test Plan:
- Single op: req0 a=0x40400000, b=0x40800000, sub=0, out_ready=1 → next cycle out_valid=1, out_result=0x40E00000, out_id=0, flags=000.
- Round-robin: NUM_REQ=4, all valid continuously, each requester with distinct operands (req1 0x410B3333+0x3E99999A) → out_id sequence 0,1,2,3,0. out_result for id1 is 0x41100000, one result per cycle.
- Backpressure: result pending, out_ready=0 for 3 cycles while req2 is valid → req_ready=0 and outputs stable for all 3 cycles. When out_ready rises, req2 is granted and its result appears on the next cycle.
- Subtract and flags: req3 a=0x7F800000 (+inf), b=0x7F800000, sub=1 → out_flags[2]=1 (invalid_operation), out_id=3. Next op 0x469C4600+0x3DCCCCCD → 0x469C4633 with flags=000.
- Pointer fairness: only req1 valid (grant 1), then req0 and req2 both valid → req2 is granted before req0.
- Async reset: assert rst between clock edges while out_valid=1 → out_valid=0 immediately. After release, the first grant goes to the lowest valid index starting from 0.
